// File: rtl/mc_maindec.sv
// rtl/mc_maindec.sv - multicycle MIPS main-control FSM
//
// Sequences fetch/decode/execute/memory/writeback and issues datapath
// enables plus the 3-bit aluop for the downstream ALU decoder.
// Build option: define BNE_SUPPORT_EN to accept bne; otherwise bne is an
// illegal opcode and branchne is tied low.
//
// Ports:
//   clk, reset (async, active-low), op[5:0] (IR opcode), mem_ready
//   memwrite, irwrite, pcwrite, branch, branchne, iord, regdst, memtoreg,
//   regwrite, alusrca, alusrcb[1:0], pcsrc[1:0], aluop[2:0], immzext,
//   fault[1:0] (sticky: 01 illegal opcode, 10 memory timeout)
// Parameter: MEM_TIMEOUT - wait cycles per memory access before fault (0 = none)

module mc_maindec #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchne,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       immzext,
    output logic [1:0] fault
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

`ifdef BNE_SUPPORT_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [1:0]    fault_q, fault_d;
    logic          in_wait;
    logic          timeout;
    logic [2:0]    imm_aluop;
    logic          imm_zext;

    // The timeout fires in the cycle that would bring the count to the limit,
    // so MEM_TIMEOUT waiting cycles are allowed before the HALT transition.
    always_comb begin
        in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout = in_wait && !mem_ready && (MEM_TIMEOUT != 0)
                  && ((int'(wait_q) + 1) >= MEM_TIMEOUT);
    end

    // The IR holds the opcode from DECODE to the next FETCH, so IMMWB can
    // re-derive the same aluop/immzext as IMMEX straight from op.
    always_comb begin
        imm_aluop = 3'b000;
        imm_zext  = 1'b0;
        case (op)
            OP_ANDI: begin imm_aluop = 3'b011; imm_zext = 1'b1; end
            OP_ORI:  begin imm_aluop = 3'b100; imm_zext = 1'b1; end
            OP_SLTI: imm_aluop = 3'b101;
            default: imm_aluop = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) begin state_d = S_HALT; fault_d = 2'b10; end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_R:                              state_d = S_EXECUTE;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_BNE: begin
                        if (BNE_EN) state_d = S_BRANCH;
                        else begin state_d = S_HALT; fault_d = 2'b01; end
                    end
                    default: begin state_d = S_HALT; fault_d = 2'b01; end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) begin state_d = S_HALT; fault_d = 2'b10; end
            end
            S_MEMWR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) begin state_d = S_HALT; fault_d = 2'b10; end
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_IMMEX:   state_d = S_IMMWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
        // Counting only while staying in a wait state makes every entry and
        // every mem_ready cycle restart the count from zero.
        if (in_wait && !mem_ready && (state_d == state_q) && (int'(wait_q) < MEM_TIMEOUT))
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        memwrite = 1'b0; irwrite  = 1'b0; pcwrite  = 1'b0; branch   = 1'b0;
        branchne = 1'b0; iord     = 1'b0; regdst   = 1'b0; memtoreg = 1'b0;
        regwrite = 1'b0; alusrca  = 1'b0; alusrcb  = 2'b00; pcsrc   = 2'b00;
        aluop    = 3'b000; immzext = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
            S_MEMWR:   begin iord = 1'b1; memwrite = !timeout; end
            S_EXECUTE: begin alusrca = 1'b1; aluop = 3'b010; end
            S_ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 3'b001;
                pcsrc    = 2'b01;
                branch   = (op == OP_BEQ);
                branchne = BNE_EN && (op == OP_BNE);
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = imm_aluop;
                immzext = imm_zext;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                aluop    = imm_aluop;
                immzext  = imm_zext;
            end
            S_JUMP:  begin pcsrc = 2'b10; pcwrite = 1'b1; end
            default: ;
        endcase
        fault = fault_q;
    end

endmodule

// File: tb/tb_mc_maindec.sv
// tb/tb_mc_maindec.sv - directed table-driven bench for mc_maindec

module tb_mc_maindec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ILL = 6'b111111;

    // {memwrite,irwrite,pcwrite,branch,branchne,iord,regdst,memtoreg,regwrite,
    //  alusrca,alusrcb[2],pcsrc[2],aluop[3],immzext,fault[2]}
    localparam logic [19:0] E_FW    = 20'b0_0_0_0_0_0_0_0_0_0_01_00_000_0_00;
    localparam logic [19:0] E_FR    = 20'b0_1_1_0_0_0_0_0_0_0_01_00_000_0_00;
    localparam logic [19:0] E_DEC   = 20'b0_0_0_0_0_0_0_0_0_0_11_00_000_0_00;
    localparam logic [19:0] E_MADR  = 20'b0_0_0_0_0_0_0_0_0_1_10_00_000_0_00;
    localparam logic [19:0] E_MRD   = 20'b0_0_0_0_0_1_0_0_0_0_00_00_000_0_00;
    localparam logic [19:0] E_MWB   = 20'b0_0_0_0_0_0_0_1_1_0_00_00_000_0_00;
    localparam logic [19:0] E_MWR   = 20'b1_0_0_0_0_1_0_0_0_0_00_00_000_0_00;
    localparam logic [19:0] E_MWRTO = 20'b0_0_0_0_0_1_0_0_0_0_00_00_000_0_00;
    localparam logic [19:0] E_EX    = 20'b0_0_0_0_0_0_0_0_0_1_00_00_010_0_00;
    localparam logic [19:0] E_AWB   = 20'b0_0_0_0_0_0_1_0_1_0_00_00_000_0_00;
    localparam logic [19:0] E_BEQ   = 20'b0_0_0_1_0_0_0_0_0_1_00_01_001_0_00;
    localparam logic [19:0] E_BNE   = 20'b0_0_0_0_1_0_0_0_0_1_00_01_001_0_00;
    localparam logic [19:0] E_JMP   = 20'b0_0_1_0_0_0_0_0_0_0_00_10_000_0_00;
    localparam logic [19:0] E_IXORI = 20'b0_0_0_0_0_0_0_0_0_1_10_00_100_1_00;
    localparam logic [19:0] E_IWORI = 20'b0_0_0_0_0_0_0_0_1_0_00_00_100_1_00;
    localparam logic [19:0] E_IXAND = 20'b0_0_0_0_0_0_0_0_0_1_10_00_011_1_00;
    localparam logic [19:0] E_IWAND = 20'b0_0_0_0_0_0_0_0_1_0_00_00_011_1_00;
    localparam logic [19:0] E_IXSLT = 20'b0_0_0_0_0_0_0_0_0_1_10_00_101_0_00;
    localparam logic [19:0] E_IWSLT = 20'b0_0_0_0_0_0_0_0_1_0_00_00_101_0_00;
    localparam logic [19:0] E_IXADD = 20'b0_0_0_0_0_0_0_0_0_1_10_00_000_0_00;
    localparam logic [19:0] E_IWADD = 20'b0_0_0_0_0_0_0_0_1_0_00_00_000_0_00;
    localparam logic [19:0] E_H01   = 20'b0_0_0_0_0_0_0_0_0_0_00_00_000_0_01;
    localparam logic [19:0] E_H10   = 20'b0_0_0_0_0_0_0_0_0_0_00_00_000_0_10;

    logic       rst_n, mem_ready;
    logic [5:0] op;
    logic       memwrite, irwrite, pcwrite, branch, branchne, iord, regdst, memtoreg, regwrite, alusrca, immzext;
    logic [1:0] alusrcb, pcsrc, fault;
    logic [2:0] aluop;
    logic [19:0] outs;

    logic       rst_t, mem_ready_t;
    logic [5:0] op_t;
    logic       memwrite_t, irwrite_t, pcwrite_t, branch_t, branchne_t, iord_t, regdst_t, memtoreg_t, regwrite_t, alusrca_t, immzext_t;
    logic [1:0] alusrcb_t, pcsrc_t, fault_t;
    logic [2:0] aluop_t;
    logic [19:0] outs_t;

    mc_maindec dut (
        .clk(clk), .reset(rst_n), .op(op), .mem_ready(mem_ready),
        .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .branchne(branchne), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .immzext(immzext), .fault(fault)
    );

    mc_maindec #(.MEM_TIMEOUT(3)) dut_t (
        .clk(clk), .reset(rst_t), .op(op_t), .mem_ready(mem_ready_t),
        .memwrite(memwrite_t), .irwrite(irwrite_t), .pcwrite(pcwrite_t), .branch(branch_t),
        .branchne(branchne_t), .iord(iord_t), .regdst(regdst_t), .memtoreg(memtoreg_t),
        .regwrite(regwrite_t), .alusrca(alusrca_t), .alusrcb(alusrcb_t), .pcsrc(pcsrc_t),
        .aluop(aluop_t), .immzext(immzext_t), .fault(fault_t)
    );

    assign outs   = {memwrite, irwrite, pcwrite, branch, branchne, iord, regdst, memtoreg,
                     regwrite, alusrca, alusrcb, pcsrc, aluop, immzext, fault};
    assign outs_t = {memwrite_t, irwrite_t, pcwrite_t, branch_t, branchne_t, iord_t, regdst_t,
                     memtoreg_t, regwrite_t, alusrca_t, alusrcb_t, pcsrc_t, aluop_t, immzext_t, fault_t};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    vec_t tv[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic m, input logic [19:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.mr = m; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] o, input logic m);
        @(negedge clk);
        rst_n = r; op = o; mem_ready = m;
        #1;
    endtask

    task automatic step_t(input logic r, input logic [5:0] o, input logic m);
        @(negedge clk);
        rst_t = r; op_t = o; mem_ready_t = m;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; op = R; mem_ready = 1'b0;
        rst_t = 1'b0; op_t = R; mem_ready_t = 1'b0;

        add(0, R, 0, E_FW);    add(0, R, 1, E_FR);
        // lw, 5 cycles
        add(1, LW, 1, E_FR);   add(1, LW, 1, E_DEC);  add(1, LW, 1, E_MADR);
        add(1, LW, 1, E_MRD);  add(1, LW, 1, E_MWB);
        // R-type
        add(1, R, 1, E_FR);    add(1, R, 1, E_DEC);   add(1, R, 1, E_EX);   add(1, R, 1, E_AWB);
        // beq, j
        add(1, BEQ, 1, E_FR);  add(1, BEQ, 1, E_DEC); add(1, BEQ, 1, E_BEQ);
        add(1, J, 1, E_FR);    add(1, J, 1, E_DEC);   add(1, J, 1, E_JMP);
        // immediates
        add(1, ORI, 1, E_FR);  add(1, ORI, 1, E_DEC);  add(1, ORI, 1, E_IXORI);  add(1, ORI, 1, E_IWORI);
        add(1, ANDI, 1, E_FR); add(1, ANDI, 1, E_DEC); add(1, ANDI, 1, E_IXAND); add(1, ANDI, 1, E_IWAND);
        add(1, SLTI, 1, E_FR); add(1, SLTI, 1, E_DEC); add(1, SLTI, 1, E_IXSLT); add(1, SLTI, 1, E_IWSLT);
        add(1, ADDI, 1, E_FR); add(1, ADDI, 1, E_DEC); add(1, ADDI, 1, E_IXADD); add(1, ADDI, 1, E_IWADD);
        // sw with three wait cycles in MEMWR
        add(1, SW, 1, E_FR);   add(1, SW, 1, E_DEC);  add(1, SW, 1, E_MADR);
        add(1, SW, 0, E_MWR);  add(1, SW, 0, E_MWR);  add(1, SW, 0, E_MWR);  add(1, SW, 1, E_MWR);
        // fetch stall then lw with a MEMRD wait
        add(1, LW, 0, E_FW);   add(1, LW, 0, E_FW);   add(1, LW, 1, E_FR);   add(1, LW, 1, E_DEC);
        add(1, LW, 1, E_MADR); add(1, LW, 0, E_MRD);  add(1, LW, 1, E_MRD);  add(1, LW, 1, E_MWB);
        // illegal opcode, HALT ignores mem_ready, reset recovers
        add(1, ILL, 1, E_FR);  add(1, ILL, 1, E_DEC); add(1, ILL, 0, E_H01);
        add(1, ILL, 1, E_H01); add(1, ILL, 0, E_H01); add(1, ILL, 1, E_H01);
        add(0, R, 0, E_FW);
        // reset mid-EXECUTE
        add(1, R, 1, E_FR);    add(1, R, 1, E_DEC);   add(1, R, 1, E_EX);
        add(0, R, 0, E_FW);    add(1, R, 0, E_FW);    add(1, R, 1, E_FR);

        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].op, tv[i].mr);
            chk("vec", i, outs, tv[i].exp);
        end

        // bne: dispatch depends on the build option
        step(0, BNE, 1);
        step(1, BNE, 1); chk("bne_fetch", 0, outs, E_FR);
        step(1, BNE, 1); chk("bne_decode", 0, outs, E_DEC);
`ifdef BNE_SUPPORT_EN
        step(1, BNE, 1); chk("bne_cyc3", 0, outs, E_BNE);
        step(1, BNE, 1); chk("bne_after", 0, outs, E_FR);
`else
        step(1, BNE, 1); chk("bne_cyc3", 0, outs, E_H01);
        step(1, BNE, 1); chk("bne_after", 0, outs, E_H01);
`endif

        // MEM_TIMEOUT=3: FETCH never sees mem_ready
        step_t(0, R, 0);
        for (int k = 0; k < 3; k++) begin
            step_t(1, R, 0); chk("to_fetch_wait", k, outs_t, E_FW);
        end
        step_t(1, R, 1); chk("to_fetch_halt", 0, outs_t, E_H10);
        step_t(1, R, 0); chk("to_fetch_halt", 1, outs_t, E_H10);

        // mem_ready arriving on the limit cycle completes the fetch
        step_t(0, R, 0);
        step_t(1, R, 0); chk("to_edge", 0, outs_t, E_FW);
        step_t(1, R, 0); chk("to_edge", 1, outs_t, E_FW);
        step_t(1, R, 1); chk("to_edge", 2, outs_t, E_FR);
        step_t(1, R, 1); chk("to_edge", 3, outs_t, E_DEC);
        step_t(1, R, 1); chk("to_edge", 4, outs_t, E_EX);

        // MEMWR timeout: strobe dropped on the timeout cycle
        step_t(0, SW, 0);
        step_t(1, SW, 1); chk("to_sw", 0, outs_t, E_FR);
        step_t(1, SW, 1); chk("to_sw", 1, outs_t, E_DEC);
        step_t(1, SW, 1); chk("to_sw", 2, outs_t, E_MADR);
        step_t(1, SW, 0); chk("to_sw", 3, outs_t, E_MWR);
        step_t(1, SW, 0); chk("to_sw", 4, outs_t, E_MWR);
        step_t(1, SW, 0); chk("to_sw", 5, outs_t, E_MWRTO);
        step_t(1, SW, 1); chk("to_sw", 6, outs_t, E_H10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
